// File: rtl/branch_predictor_if.sv
// Pipeline-side bundle for the branch predictor: fetch lookup, EX resolution
// feedback, misprediction/redirect result and the saturating perf counters.
interface branch_predictor_if #(
    parameter int PERF_W = 32
);
    logic              clear;
    logic [31:0]       lk_pc;
    logic              lk_taken;
    logic [31:0]       lk_target;
    logic              upd_en;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_pred_taken;
    logic [31:0]       upd_pred_target;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output clear, lk_pc, upd_en, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  lk_taken, lk_target, mispredict, redirect_pc,
               perf_branches, perf_mispredicts
    );

    modport slave (
        input  clear, lk_pc, upd_en, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output lk_taken, lk_target, mispredict, redirect_pc,
               perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational fetch lookup, EX-stage training and saturating perf counters.
module branch_predictor #(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         PERF_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        if (taken) begin
            r = (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            r = (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
        return r;
    endfunction

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic inc);
        logic [PERF_W-1:0] r;
        if (inc && !(&v)) begin
            r = v + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    logic [29:0]        target_d [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];
    logic [1:0]         cnt_d    [ENTRIES];
    logic [PERF_W-1:0]  perf_br_q, perf_br_d;
    logic [PERF_W-1:0]  perf_mp_q, perf_mp_d;

    logic [IDX_W-1:0]   lk_idx_s;
    logic               lk_hit_s;
    logic               lk_taken_s;
    logic [IDX_W-1:0]   upd_idx_s;
    logic               upd_hit_s;
    logic               mispredict_s;

    assign lk_idx_s  = bp.lk_pc[IDX_W+1:2];
    assign upd_idx_s = bp.upd_pc[IDX_W+1:2];

    always_comb begin
        lk_hit_s   = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == bp.lk_pc[31:IDX_W+2]);
        lk_taken_s = lk_hit_s && cnt_q[lk_idx_s][1];
        upd_hit_s  = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == bp.upd_pc[31:IDX_W+2]);
    end

    // The redirect/flush path must see the verdict in the resolving cycle, so it stays combinational.
    always_comb begin
        mispredict_s = bp.upd_en &&
                       ((bp.upd_pred_taken != bp.upd_taken) ||
                        (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
    end

    assign bp.lk_taken    = lk_taken_s;
    assign bp.lk_target   = lk_taken_s ? {target_q[lk_idx_s], 2'b00} : bp.lk_pc + 32'd4;
    assign bp.mispredict  = mispredict_s;
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

    // Table training; clear wins over a same-cycle update, untaken misses leave the table alone.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (bp.clear) begin
            valid_d = '0;
        end else if (bp.upd_en) begin
            if (upd_hit_s) begin
                cnt_d[upd_idx_s] = cnt_step(cnt_q[upd_idx_s], bp.upd_taken);
                if (bp.upd_taken) begin
                    target_d[upd_idx_s] = bp.upd_target[31:2];
                end else begin
                    target_d[upd_idx_s] = target_q[upd_idx_s];
                end
            end else if (bp.upd_taken) begin
                valid_d[upd_idx_s]  = 1'b1;
                tag_d[upd_idx_s]    = bp.upd_pc[31:IDX_W+2];
                target_d[upd_idx_s] = bp.upd_target[31:2];
                cnt_d[upd_idx_s]    = 2'b10;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    always_comb begin
        perf_br_d = sat_inc(perf_br_q, bp.upd_en);
        perf_mp_d = sat_inc(perf_mp_q, mispredict_s);
    end

    // Reset takes priority over clear and update in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q   <= '0;
            perf_br_q <= '0;
            perf_mp_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign bp.perf_branches    = perf_br_q;
    assign bp.perf_mispredicts = perf_mp_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed vector table, perf saturation on a 4-bit copy,
// randomized traffic against a behavioural table model, and reset-with-update.
module tb_branch_predictor;
    localparam int N     = 16;
    localparam int TAGSH = $clog2(N) + 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    branch_predictor_if #(.PERF_W(32)) bp ();
    branch_predictor_if #(.PERF_W(4))  bp4 ();

    branch_predictor #(.ENTRIES(N), .CNT_INIT(2'b01), .PERF_W(32)) dut (
        .CLK(CLK), .RST(RST), .bp(bp)
    );
    branch_predictor #(.ENTRIES(N), .CNT_INIT(2'b01), .PERF_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .bp(bp4)
    );

    assign bp4.clear           = bp.clear;
    assign bp4.lk_pc           = bp.lk_pc;
    assign bp4.upd_en          = bp.upd_en;
    assign bp4.upd_pc          = bp.upd_pc;
    assign bp4.upd_taken       = bp.upd_taken;
    assign bp4.upd_target      = bp.upd_target;
    assign bp4.upd_pred_taken  = bp.upd_pred_taken;
    assign bp4.upd_pred_target = bp.upd_pred_target;

    int total = 0;
    int bad   = 0;

    // Reference model: which branch PC owns each slot, its target and a 0..3 confidence.
    bit          m_v   [N];
    logic [31:0] m_own [N];
    logic [31:0] m_tgt [N];
    int          m_cnt [N];
    longint      m_br;
    longint      m_mp;

    typedef struct {
        logic        clr;
        logic        en;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic [31:0] lk;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic        e_mp;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic clr, input logic en, input logic [31:0] pc,
                                input logic tk, input logic [31:0] tgt, input logic ptk,
                                input logic [31:0] ptgt, input logic [31:0] lk,
                                input logic e_tk, input logic [31:0] e_tgt,
                                input logic e_mp, input logic [31:0] e_rd);
        vec_t v;
        v.clr = clr; v.en = en; v.pc = pc; v.tk = tk; v.tgt = tgt; v.ptk = ptk;
        v.ptgt = ptgt; v.lk = lk; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_mp = e_mp; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_exp(input longint v, input longint mx);
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    task automatic m_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 1'b0; m_own[k] = 32'd0; m_tgt[k] = 32'd0; m_cnt[k] = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) % N);
        return m_v[i] && ((m_own[i] >> TAGSH) == (pc >> TAGSH));
    endfunction

    task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i  = int'((pc >> 2) % N);
        tk = m_hit(pc) && (m_cnt[i] >= 2);
        tg = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    function automatic logic m_mispredict();
        return bp.upd_en && ((bp.upd_pred_taken != bp.upd_taken) ||
                             (bp.upd_taken && bp.upd_pred_target != bp.upd_target));
    endfunction

    task automatic m_edge();
        int i;
        if (RST) begin
            m_reset();
        end else begin
            if (bp.upd_en) m_br++;
            if (m_mispredict()) m_mp++;
            i = int'((bp.upd_pc >> 2) % N);
            if (bp.clear) begin
                for (int k = 0; k < N; k++) m_v[k] = 1'b0;
            end else if (bp.upd_en && m_hit(bp.upd_pc)) begin
                m_cnt[i] = m_cnt[i] + (bp.upd_taken ? 1 : -1);
                if (m_cnt[i] > 3) m_cnt[i] = 3;
                if (m_cnt[i] < 0) m_cnt[i] = 0;
                if (bp.upd_taken) m_tgt[i] = bp.upd_target & 32'hFFFF_FFFC;
            end else if (bp.upd_en && bp.upd_taken) begin
                m_v[i]   = 1'b1;
                m_own[i] = bp.upd_pc;
                m_tgt[i] = bp.upd_target & 32'hFFFF_FFFC;
                m_cnt[i] = 2;
            end
        end
    endtask

    task automatic model_check();
        logic        tk;
        logic [31:0] tg;
        m_lookup(bp.lk_pc, tk, tg);
        chk("lk_taken",        {31'd0, bp.lk_taken}, {31'd0, tk});
        chk("lk_target",       bp.lk_target, tg);
        chk("mispredict",      {31'd0, bp.mispredict}, {31'd0, m_mispredict()});
        chk("redirect_pc",     bp.redirect_pc, bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4);
        chk("perf_branches",   bp.perf_branches, sat_exp(m_br, 64'hFFFF_FFFF));
        chk("perf_mispred",    bp.perf_mispredicts, sat_exp(m_mp, 64'hFFFF_FFFF));
        chk("perf4_branches",  {28'd0, bp4.perf_branches}, sat_exp(m_br, 64'd15));
        chk("perf4_mispred",   {28'd0, bp4.perf_mispredicts}, sat_exp(m_mp, 64'd15));
    endtask

    task automatic check_and_clock();
        model_check();
        @(posedge CLK);
        m_edge();
        #1;
    endtask

    task automatic drive(input logic clr, input logic en, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic [31:0] lk);
        bp.clear = clr; bp.upd_en = en; bp.upd_pc = pc; bp.upd_taken = tk;
        bp.upd_target = tgt; bp.upd_pred_taken = ptk; bp.upd_pred_target = ptgt; bp.lk_pc = lk;
    endtask

    function automatic logic [31:0] rnd_pc();
        return (32'($urandom_range(0, 2)) << TAGSH) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    initial begin
        vecs[0]  = mk(1'b0, 1'b0, 32'h40,  1'b0, 32'h0,   1'b0, 32'h0,   32'h40,  1'b0, 32'h44,  1'b0, 32'h44);
        vecs[1]  = mk(1'b0, 1'b1, 32'h40,  1'b1, 32'h100, 1'b0, 32'h0,   32'h40,  1'b0, 32'h44,  1'b1, 32'h100);
        vecs[2]  = mk(1'b0, 1'b1, 32'h40,  1'b1, 32'h100, 1'b1, 32'h100, 32'h40,  1'b1, 32'h100, 1'b0, 32'h100);
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = mk(1'b0, 1'b1, 32'h40,  1'b0, 32'h100, 1'b1, 32'h100, 32'h40,  1'b1, 32'h100, 1'b1, 32'h44);
        vecs[6]  = vecs[5];
        vecs[7]  = mk(1'b0, 1'b1, 32'h40,  1'b0, 32'h100, 1'b1, 32'h100, 32'h40,  1'b0, 32'h44,  1'b1, 32'h44);
        vecs[8]  = mk(1'b0, 1'b1, 32'h40,  1'b0, 32'h100, 1'b0, 32'h0,   32'h40,  1'b0, 32'h44,  1'b0, 32'h44);
        vecs[9]  = mk(1'b0, 1'b1, 32'h40,  1'b1, 32'h100, 1'b0, 32'h0,   32'h40,  1'b0, 32'h44,  1'b1, 32'h100);
        vecs[10] = mk(1'b0, 1'b0, 32'h40,  1'b0, 32'h0,   1'b0, 32'h0,   32'h40,  1'b0, 32'h44,  1'b0, 32'h44);
        vecs[11] = mk(1'b0, 1'b1, 32'h80,  1'b1, 32'h300, 1'b0, 32'h0,   32'h80,  1'b0, 32'h84,  1'b1, 32'h300);
        vecs[12] = mk(1'b0, 1'b0, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   32'h40,  1'b0, 32'h44,  1'b0, 32'h84);
        vecs[13] = mk(1'b0, 1'b0, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   32'h80,  1'b1, 32'h300, 1'b0, 32'h84);
        vecs[14] = mk(1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0,   32'h80,  1'b1, 32'h300, 1'b1, 32'h400);
        vecs[15] = mk(1'b0, 1'b0, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   32'h200, 1'b0, 32'h204, 1'b0, 32'h204);
        vecs[16] = mk(1'b0, 1'b0, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   32'h80,  1'b0, 32'h84,  1'b0, 32'h84);
        vecs[17] = mk(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);

        RST = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge CLK);
        m_reset();
        #1;
        RST = 1'b0;

        for (int r = 0; r < 18; r++) begin
            drive(vecs[r].clr, vecs[r].en, vecs[r].pc, vecs[r].tk, vecs[r].tgt,
                  vecs[r].ptk, vecs[r].ptgt, vecs[r].lk);
            @(negedge CLK);
            chk($sformatf("vec%0d_lk_taken", r),  {31'd0, bp.lk_taken}, {31'd0, vecs[r].e_tk});
            chk($sformatf("vec%0d_lk_target", r), bp.lk_target, vecs[r].e_tgt);
            chk($sformatf("vec%0d_mispredict", r), {31'd0, bp.mispredict}, {31'd0, vecs[r].e_mp});
            chk($sformatf("vec%0d_redirect", r),  bp.redirect_pc, vecs[r].e_rd);
            check_and_clock();
        end

        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("tbl_perf_branches", bp.perf_branches, 32'd11);
        chk("tbl_perf_mispred",  bp.perf_mispredicts, 32'd7);
        check_and_clock();

        // 16 mispredicting updates push the 4-bit counters into saturation.
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b1, 32'h40 + 32'(k * 4), 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
            @(negedge CLK);
            check_and_clock();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("sat_perf4_mispred",  {28'd0, bp4.perf_mispredicts}, 32'hF);
        chk("sat_perf4_branches", {28'd0, bp4.perf_branches}, 32'hF);
        chk("sat_perf_mispred",   bp.perf_mispredicts, 32'd23);
        check_and_clock();

        for (int n = 0; n < 600; n++) begin
            logic        ptk;
            logic [31:0] ptg;
            logic [31:0] pc;
            pc = rnd_pc();
            bp.upd_pc     = pc;
            bp.upd_en     = ($urandom_range(0, 3) != 0);
            bp.upd_taken  = ($urandom_range(0, 2) != 0);
            bp.upd_target = ($urandom_range(0, 9) == 0) ? 32'($urandom)
                                                         : 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            if ($urandom_range(0, 1) == 1) begin
                m_lookup(pc, ptk, ptg);
            end else begin
                ptk = 1'($urandom_range(0, 1));
                ptg = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            end
            bp.upd_pred_taken  = ptk;
            bp.upd_pred_target = ptg;
            bp.clear = ($urandom_range(0, 29) == 0);
            RST      = ($urandom_range(0, 199) == 0);
            bp.lk_pc = ($urandom_range(0, 31) == 0) ? 32'hFFFF_FFFC : rnd_pc();
            @(negedge CLK);
            check_and_clock();
        end
        RST = 1'b0;

        // Reset in a cycle carrying a taken update: no allocation, counters cleared.
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0, 32'h40);
        @(negedge CLK);
        check_and_clock();
        RST = 1'b1;
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0, 32'h40);
        @(negedge CLK);
        chk("rst_mispredict_live", {31'd0, bp.mispredict}, 32'd1);
        check_and_clock();
        RST = 1'b0;
        drive(1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40);
        @(negedge CLK);
        chk("rst_lk_taken",   {31'd0, bp.lk_taken}, 32'd0);
        chk("rst_lk_target",  bp.lk_target, 32'h44);
        chk("rst_perf_br",    bp.perf_branches, 32'd0);
        chk("rst_perf_mp",    bp.perf_mispredicts, 32'd0);
        chk("rst_perf4_br",   {28'd0, bp4.perf_branches}, 32'd0);
        check_and_clock();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
